// File: rtl/rc5_job_scheduler.sv
// rtl/rc5_job_scheduler.sv - round-robin job scheduler in front of a shared RC5-32/12 round engine
//
// Arbitrates an encrypt and a decrypt requester onto one iterative RC5 engine.
// Key expansion is sequenced before any job is issued. Only one block is in flight at a time.
//
// Ports
//   clk, clr                      clock, synchronous active-low reset
//   enc_vld/enc_din/enc_rdy       encrypt request (64-bit plaintext {A,B})
//   dec_vld/dec_din/dec_rdy       decrypt request (64-bit ciphertext {A,B})
//   key_load/key_din              1-cycle key latch pulse and 128-bit user key
//   eng_key_ld/eng_key            key expansion pulse and latched key to engine
//   eng_key_done                  engine key table ready pulse
//   eng_start/eng_mode/eng_din    job start pulse, mode (0=enc, 1=dec), job data
//   eng_done/eng_dout             engine result pulse and data
//   res_vld/res_mode/res_dout     result output, held until res_rdy
//   res_rdy                       result consumer ready
//   key_ok                        a key has been expanded successfully
//   timeout_err                   sticky: an engine wait hit TIMEOUT_CYC
module rc5_job_scheduler #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         enc_vld,
    input  logic [63:0]  enc_din,
    output logic         enc_rdy,
    input  logic         dec_vld,
    input  logic [63:0]  dec_din,
    output logic         dec_rdy,
    input  logic         key_load,
    input  logic [127:0] key_din,
    output logic         eng_key_ld,
    output logic [127:0] eng_key,
    input  logic         eng_key_done,
    output logic         eng_start,
    output logic         eng_mode,
    output logic [63:0]  eng_din,
    input  logic         eng_done,
    input  logic [63:0]  eng_dout,
    output logic         res_vld,
    output logic         res_mode,
    output logic [63:0]  res_dout,
    input  logic         res_rdy,
    output logic         key_ok,
    output logic         timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEYLD,
        S_KEYWAIT,
        S_ISSUE,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [127:0]   r_key;
    logic           r_key_pend;
    logic           r_key_ok;
    logic           r_last_dec;
    logic [63:0]    r_din;
    logic           r_mode;
    logic [63:0]    r_res_dout;
    logic           r_res_mode;
    logic           r_res_vld;
    logic           r_timeout;
    logic [CW-1:0]  r_tcnt;

    logic           w_can_grant;
    logic           w_grant_enc;
    logic           w_grant_dec;
    logic           w_acc_enc;
    logic           w_acc_dec;
    logic           w_tmo;

    // Grants are only offered in IDLE with a valid key and no re-expansion pending.
    // On a tie the side that did not win last time gets the grant.
    assign w_can_grant = (r_state == S_IDLE) && !r_key_pend && r_key_ok;
    assign w_grant_enc = enc_vld && (!dec_vld || r_last_dec);
    assign w_grant_dec = dec_vld && (!enc_vld || !r_last_dec);
    assign w_acc_enc   = enc_vld && enc_rdy;
    assign w_acc_dec   = dec_vld && dec_rdy;
    // Counter is 0 on the first wait cycle, so this fires on wait cycle TIMEOUT_CYC.
    assign w_tmo       = (r_tcnt == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        w_state_nxt = r_state;
        enc_rdy     = 1'b0;
        dec_rdy     = 1'b0;
        eng_key_ld  = 1'b0;
        eng_start   = 1'b0;
        case (r_state)
            S_IDLE: begin
                enc_rdy = w_can_grant && w_grant_enc;
                dec_rdy = w_can_grant && w_grant_dec;
                if (r_key_pend) begin
                    w_state_nxt = S_KEYLD;
                end else if (w_acc_enc || w_acc_dec) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_KEYLD: begin
                eng_key_ld  = 1'b1;
                w_state_nxt = S_KEYWAIT;
            end
            S_KEYWAIT: begin
                if (eng_key_done || w_tmo) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                eng_start   = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    w_state_nxt = S_RESULT;
                end else if (w_tmo) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RESULT: begin
                if (res_rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state    <= S_IDLE;
            r_key      <= '0;
            r_key_pend <= 1'b0;
            r_key_ok   <= 1'b0;
            r_last_dec <= 1'b1;
            r_din      <= '0;
            r_mode     <= 1'b0;
            r_res_dout <= '0;
            r_res_mode <= 1'b0;
            r_res_vld  <= 1'b0;
            r_timeout  <= 1'b0;
            r_tcnt     <= '0;
        end else begin
            r_state <= w_state_nxt;

            // A key_load arriving during KEYLD wins, so the newer key is expanded next.
            if (key_load) begin
                r_key      <= key_din;
                r_key_pend <= 1'b1;
            end else if (r_state == S_KEYLD) begin
                r_key_pend <= 1'b0;
            end

            if (r_state == S_KEYLD) begin
                r_key_ok <= 1'b0;
            end else if ((r_state == S_KEYWAIT) && eng_key_done) begin
                r_key_ok <= 1'b1;
            end

            if (w_acc_enc) begin
                r_din      <= enc_din;
                r_mode     <= 1'b0;
                r_last_dec <= 1'b0;
            end else if (w_acc_dec) begin
                r_din      <= dec_din;
                r_mode     <= 1'b1;
                r_last_dec <= 1'b1;
            end

            // Both wait states are only entered from other states, so clearing
            // everywhere else gives a fresh count on every entry.
            if ((r_state == S_KEYWAIT) || (r_state == S_WAIT)) begin
                r_tcnt <= r_tcnt + CW'(1);
            end else begin
                r_tcnt <= '0;
            end

            if (w_tmo && (((r_state == S_KEYWAIT) && !eng_key_done) ||
                          ((r_state == S_WAIT) && !eng_done))) begin
                r_timeout <= 1'b1;
            end

            if ((r_state == S_WAIT) && eng_done) begin
                r_res_dout <= eng_dout;
                r_res_mode <= r_mode;
                r_res_vld  <= 1'b1;
            end else if ((r_state == S_RESULT) && res_rdy) begin
                r_res_vld  <= 1'b0;
            end
        end
    end

    assign eng_key     = r_key;
    assign eng_mode    = r_mode;
    assign eng_din     = r_din;
    assign res_vld     = r_res_vld;
    assign res_mode    = r_res_mode;
    assign res_dout    = r_res_dout;
    assign key_ok      = r_key_ok;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_rc5_job_scheduler.sv
// tb/tb_rc5_job_scheduler.sv - self-checking bench for rc5_job_scheduler
module tb_rc5_job_scheduler;

    logic         clk = 1'b0;
    logic         clr;
    logic         enc_vld, dec_vld, enc_rdy, dec_rdy;
    logic [63:0]  enc_din, dec_din;
    logic         key_load;
    logic [127:0] key_din;
    logic         eng_key_ld;
    logic [127:0] eng_key;
    logic         eng_key_done = 1'b0;
    logic         eng_start, eng_mode;
    logic [63:0]  eng_din;
    logic         eng_done = 1'b0;
    logic [63:0]  eng_dout = '0;
    logic         res_vld, res_mode, res_rdy;
    logic [63:0]  res_dout;
    logic         key_ok, timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rc5_job_scheduler #(.TIMEOUT_CYC(64)) dut (
        .clk(clk), .clr(clr),
        .enc_vld(enc_vld), .enc_din(enc_din), .enc_rdy(enc_rdy),
        .dec_vld(dec_vld), .dec_din(dec_din), .dec_rdy(dec_rdy),
        .key_load(key_load), .key_din(key_din),
        .eng_key_ld(eng_key_ld), .eng_key(eng_key), .eng_key_done(eng_key_done),
        .eng_start(eng_start), .eng_mode(eng_mode), .eng_din(eng_din),
        .eng_done(eng_done), .eng_dout(eng_dout),
        .res_vld(res_vld), .res_mode(res_mode), .res_dout(res_dout), .res_rdy(res_rdy),
        .key_ok(key_ok), .timeout_err(timeout_err)
    );

    // Engine model: done pulse L cycles after the start cycle, result = ~din.
    bit          eng_en  = 1'b1;
    int          eng_lat = 13;
    int          ecnt    = 0;
    logic [63:0] e_data  = '0;
    always @(negedge clk) begin
        eng_done = 1'b0;
        if (ecnt > 0) begin
            ecnt--;
            if (ecnt == 0) begin
                eng_done = 1'b1;
                eng_dout = ~e_data;
            end
        end else if (eng_start && eng_en) begin
            ecnt   = eng_lat;
            e_data = eng_din;
        end
    end

    // Key expansion model: done pulse 5 cycles after eng_key_ld.
    int kcnt      = 0;
    int kdone_cyc = -100;
    always @(negedge clk) begin
        eng_key_done = 1'b0;
        if (kcnt > 0) begin
            kcnt--;
            if (kcnt == 0) begin
                eng_key_done = 1'b1;
                kdone_cyc    = cyc;
            end
        end else if (eng_key_ld) begin
            kcnt = 5;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Offers one block on a side; t is the handshake cycle. Returns at cycle t+1 with vld dropped.
    task automatic offer(input bit dec, input logic [63:0] din, output int t);
        t = -1;
        for (int i = 0; i < 300 && t < 0; i++) begin
            if (dec) begin dec_vld = 1'b1; dec_din = din; end
            else     begin enc_vld = 1'b1; enc_din = din; end
            #1;
            if (dec ? dec_rdy : enc_rdy) t = cyc;
            @(negedge clk);
        end
        enc_vld = 1'b0;
        dec_vld = 1'b0;
        if (t < 0) chk("offer_bound", 1, 0);
    endtask

    task automatic wait_res(output int t);
        t = -1;
        for (int i = 0; i < 300 && t < 0; i++) begin
            @(negedge clk);
            if (res_vld) t = cyc;
        end
        if (t < 0) chk("res_bound", 1, 0);
    endtask

    task automatic consume();
        res_rdy = 1'b1;
        @(negedge clk);
        chk("consume_drop", res_vld, 0);
        res_rdy = 1'b0;
    endtask

    typedef struct {
        logic        mode;
        logic [63:0] din;
        logic [63:0] dout;
    } vec_t;

    vec_t        tbl[6];
    logic [63:0] encd[4];
    logic [63:0] decd[4];

    initial begin
        int t, tr, bad, kp, kok, eq, dq, got;

        // Last grant before this table is ENC, so the first tie goes to DEC.
        tbl[0] = '{1'b1, 64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF};
        tbl[1] = '{1'b0, 64'hFFFF0000FFFF0000, 64'h0000FFFF0000FFFF};
        tbl[2] = '{1'b1, 64'h1111111111111111, 64'hEEEEEEEEEEEEEEEE};
        tbl[3] = '{1'b0, 64'h8000000000000001, 64'h7FFFFFFFFFFFFFFE};
        tbl[4] = '{1'b1, 64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0};
        tbl[5] = '{1'b0, 64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A};

        clr = 1'b0; enc_vld = 0; dec_vld = 0; enc_din = '0; dec_din = '0;
        key_load = 0; key_din = '0; res_rdy = 0;
        repeat (3) @(negedge clk);
        chk("rst_enc_rdy", enc_rdy, 0);
        chk("rst_dec_rdy", dec_rdy, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_eng_key_ld", eng_key_ld, 0);
        chk("rst_res_vld", res_vld, 0);
        chk("rst_key_ok", key_ok, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_eng_key", eng_key, 0);
        chk("rst_eng_din", eng_din, 0);
        clr = 1'b1;

        // Requests stall without a key
        enc_vld = 1'b1; enc_din = 64'h1234;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (enc_rdy || eng_start) bad++;
        end
        chk("nokey_stall", bad, 0);
        enc_vld = 1'b0;

        // Key load
        key_din  = 128'h000102030405060708090A0B0C0D0E0F;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        kp = 0; kok = -1;
        for (int i = 0; i < 40 && kok < 0; i++) begin
            @(negedge clk);
            if (eng_key_ld) kp++;
            if (key_ok) kok = cyc;
        end
        chk("key_ld_pulses", kp, 1);
        chk("key_ok_timing", kok, kdone_cyc + 1);
        chk("eng_key", eng_key, 128'h000102030405060708090A0B0C0D0E0F);

        // Single encrypt, L=13
        offer(1'b0, 64'h0123456789ABCDEF, t);
        wait_res(tr);
        chk("enc_latency", tr - t, 15);
        chk("enc_dout", res_dout, 64'hFEDCBA9876543210);
        chk("enc_mode", res_mode, 0);
        consume();

        // Round-robin with both requesters held
        eq = 0; dq = 0;
        foreach (tbl[i]) begin
            if (tbl[i].mode) begin decd[dq] = tbl[i].din; dq++; end
            else             begin encd[eq] = tbl[i].din; eq++; end
        end
        encd[3] = '0; decd[3] = '0;
        eq = 0; dq = 0;
        res_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            got = -1;
            for (int k = 0; k < 300 && got < 0; k++) begin
                enc_vld = (eq < 3); enc_din = encd[eq];
                dec_vld = (dq < 3); dec_din = decd[dq];
                #1;
                if (enc_vld && enc_rdy) got = 0;
                else if (dec_vld && dec_rdy) got = 1;
                @(negedge clk);
            end
            chk("rr_grant", got, tbl[i].mode);
            chk("rr_eng_din", eng_din, tbl[i].din);
            if (got == 0) eq++;
            else if (got == 1) dq++;
            enc_vld = (eq < 3); enc_din = encd[eq];
            dec_vld = (dq < 3); dec_din = decd[dq];
            wait_res(tr);
            chk("rr_res_mode", res_mode, tbl[i].mode);
            chk("rr_res_dout", res_dout, tbl[i].dout);
        end
        enc_vld = 1'b0; dec_vld = 1'b0;
        chk("rr_no_loss", {eq[3:0], dq[3:0]}, 8'h33);
        @(negedge clk);
        res_rdy = 1'b0;

        // Result backpressure
        offer(1'b0, 64'hDEADBEEF00C0FFEE, t);
        wait_res(tr);
        enc_vld = 1'b1; enc_din = 64'h5555;
        dec_vld = 1'b1; dec_din = 64'h00000000FFFFFFFF;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!res_vld || res_dout !== 64'h21524110FF3F0011 || res_mode !== 1'b0 ||
                enc_rdy || dec_rdy || eng_start) bad++;
        end
        chk("bp_hold", bad, 0);
        res_rdy = 1'b1;
        @(negedge clk);
        chk("bp_release", res_vld, 0);
        chk("bp_next_grant", {enc_rdy, dec_rdy}, 2'b01);
        @(negedge clk);
        enc_vld = 1'b0; dec_vld = 1'b0;
        chk("bp_eng_start", eng_start, 1);
        chk("bp_eng_mode", eng_mode, 1);
        wait_res(tr);
        chk("bp_next_dout", res_dout, 64'hFFFFFFFF00000000);
        @(negedge clk);
        res_rdy = 1'b0;

        // Engine timeout
        eng_en = 1'b0;
        offer(1'b0, 64'hCAFE, t);
        tr = -1; bad = 0;
        for (int i = 0; i < 300 && tr < 0; i++) begin
            @(negedge clk);
            if (res_vld) bad++;
            if (timeout_err) tr = cyc;
        end
        chk("tmo_cycle", tr - t, 66);
        chk("tmo_no_result", bad, 0);
        eng_en = 1'b1;
        offer(1'b1, 64'h00FF00FF00FF00FF, t);
        wait_res(tr);
        chk("tmo_next_dout", res_dout, 64'hFF00FF00FF00FF00);
        chk("tmo_next_mode", res_mode, 1);
        chk("tmo_sticky", timeout_err, 1);
        consume();

        // Reset mid-job
        offer(1'b0, 64'hBEEF, t);
        repeat (4) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        enc_vld = 1'b1; enc_din = 64'h7777;
        res_rdy = 1'b1;
        bad = 0;
        repeat (25) begin
            @(negedge clk);
            if (res_vld || enc_rdy || eng_start) bad++;
        end
        enc_vld = 1'b0;
        chk("midrst_quiet", bad, 0);
        chk("midrst_key_ok", key_ok, 0);
        chk("midrst_timeout", timeout_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
